// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access with data priority and a hang timeout.
// Define ARB_STARVE_GUARD_EN to bound instruction-fetch starvation under continuous data traffic.
module mem_arbiter #(
`ifdef ARB_STARVE_GUARD_EN
  parameter int unsigned STARVE_LIMIT = 4,
`endif
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        err,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;

  logic in_serv;
  logic access_hit;
  logic abort_hit;
  logic done;
  logic d_req;
  logic inst_first;

  assign d_req      = dREN | dWEN;
  assign in_serv    = (state_q != IDLE);
  assign access_hit = in_serv & (ramstate == RS_ACCESS);
  // ACCESS beats a coincident timeout so valid data is never discarded.
  assign abort_hit  = in_serv & ~access_hit &
                      ((ramstate == RS_ERROR) | (timer_q == TIMEOUT_C));
  assign done       = access_hit | abort_hit;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign inst_first = iREN & (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (state_d == ISERV) begin
        starve_d = 4'd0;
      end else if ((state_d == DSERV) && iREN && (starve_q != 4'hF)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end
`else
  assign inst_first = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inst_first) begin
          state_d = ISERV;
        end else if (d_req) begin
          state_d = DSERV;
        end else if (iREN) begin
          state_d = ISERV;
        end
      end
      ISERV, DSERV: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts at every grant and saturates instead of wrapping.
  always_comb begin
    timer_d = 8'd0;
    if (in_serv && !done) begin
      timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      timer_q  <= 8'd0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (state_q)
      ISERV: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DSERV: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = iREN  & ~((state_q == ISERV) & done);
  assign dwait = d_req & ~((state_q == DSERV) & done);
  assign iload = ((state_q == ISERV) && access_hit) ? ramload : 32'd0;
  assign dload = ((state_q == DSERV) && access_hit) ? ramload : 32'd0;
  assign err   = abort_hit;

endmodule
